// File: rtl/vx_csr_router.sv
// Routes one outstanding CSR request to one of NUM_CHANNELS address-windowed slaves and returns a registered response.
// Optional feature macro: CSR_ROUTER_TIMEOUT_EN enables the REQ/WAIT abort timer, rsp_err and timeout_cnt.
module vx_csr_router #(
  parameter int                          NUM_LANES      = 4,
  parameter int                          NUM_CHANNELS   = 3,
  parameter int                          WID_WIDTH      = 2,
  parameter int                          TAG_WIDTH      = 32,
  parameter logic [NUM_CHANNELS*12-1:0]  CH_BASE        = {NUM_CHANNELS{12'h0}},
  parameter logic [NUM_CHANNELS*12-1:0]  CH_SIZE        = {NUM_CHANNELS{12'h0}},
  parameter int                          TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [11:0]                       req_addr,
  input  logic [WID_WIDTH-1:0]              req_wid,
  input  logic [NUM_LANES-1:0]              req_tmask,
  input  logic [NUM_LANES*32-1:0]           req_data,
  input  logic [TAG_WIDTH-1:0]              req_tag,
  output logic [NUM_CHANNELS-1:0]           ch_req_valid,
  input  logic [NUM_CHANNELS-1:0]           ch_req_ready,
  output logic                              ch_req_write,
  output logic [11:0]                       ch_req_addr,
  output logic [WID_WIDTH-1:0]              ch_req_wid,
  output logic [NUM_LANES-1:0]              ch_req_tmask,
  output logic [NUM_LANES*32-1:0]           ch_req_data,
  input  logic [NUM_CHANNELS-1:0]           ch_rsp_valid,
  input  logic [NUM_CHANNELS*NUM_LANES*32-1:0] ch_rsp_data,
  output logic [NUM_CHANNELS-1:0]           ch_rsp_ready,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [WID_WIDTH-1:0]              rsp_wid,
  output logic [NUM_LANES-1:0]              rsp_tmask,
  output logic [NUM_LANES*32-1:0]           rsp_data,
  output logic [TAG_WIDTH-1:0]              rsp_tag,
  output logic                              rsp_miss,
  output logic                              rsp_err,
  output logic [7:0]                        timeout_cnt
);

  localparam int DW = NUM_LANES * 32;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("vx_csr_router: parameter out of range");
  end

  state_t                  state_q;
  logic                    ready_q;
  logic                    write_q;
  logic [11:0]             addr_q;
  logic [WID_WIDTH-1:0]    wid_q;
  logic [NUM_LANES-1:0]    tmask_q;
  logic [DW-1:0]           wdata_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [NUM_CHANNELS-1:0] sel_q;
  logic [DW-1:0]           rdata_q;
  logic                    miss_q;

  logic [NUM_CHANNELS-1:0] hit;
  logic [NUM_CHANNELS-1:0] first_hit;
  logic [DW-1:0]           rsp_mux;
  logic                    accept;
  logic                    req_hs;
  logic                    rsp_hs;
  logic                    expire;

  // 13-bit compare so base+size can reach 4096 without wrapping
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_decode
    localparam logic [12:0] LO = {1'b0, CH_BASE[gi*12 +: 12]};
    localparam logic [12:0] HI = LO + {1'b0, CH_SIZE[gi*12 +: 12]};
    assign hit[gi] = ({1'b0, req_addr} >= LO) && ({1'b0, req_addr} < HI);
  end

  assign first_hit = hit & (~hit + NUM_CHANNELS'(1));

  always_comb begin
    rsp_mux = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rsp_mux = rsp_mux | (ch_rsp_data[i*DW +: DW] & {DW{sel_q[i]}});
    end
  end

  assign accept = (state_q == S_IDLE) && ready_q && req_valid;
  assign req_hs = (state_q == S_REQ)  && |(sel_q & ch_req_ready);
  assign rsp_hs = (state_q == S_WAIT) && |(sel_q & ch_rsp_valid);

`ifdef CSR_ROUTER_TIMEOUT_EN
  logic [15:0] tcnt_q;
  logic        err_q;
  logic [7:0]  tocnt_q;

  assign expire = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                  (({1'b0, tcnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      tocnt_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        tcnt_q <= '0;
      end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
        tcnt_q <= tcnt_q + 16'd1;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (expire && !req_hs && !rsp_hs) begin
        err_q <= 1'b1;
        if (tocnt_q != 8'hFF) tocnt_q <= tocnt_q + 8'd1;
      end
    end
  end

  assign rsp_err     = err_q;
  assign timeout_cnt = tocnt_q;
`else
  assign expire      = 1'b0;
  assign rsp_err     = 1'b0;
  assign timeout_cnt = 8'h00;
`endif

  // ready_q stays low for the first cycle out of reset so every output reads 0 under reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wid_q   <= '0;
      tmask_q <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            write_q <= req_write;
            addr_q  <= req_addr;
            wid_q   <= req_wid;
            tmask_q <= req_tmask;
            wdata_q <= req_data;
            tag_q   <= req_tag;
            sel_q   <= first_hit;
            rdata_q <= '0;
            miss_q  <= ~|hit;
            state_q <= (|hit) ? S_REQ : S_RSP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (req_hs) begin
            state_q <= write_q ? S_RSP : S_WAIT;
          end else if (expire) begin
            rdata_q <= '1;
            state_q <= S_RSP;
          end
        end
        S_WAIT: begin
          if (rsp_hs) begin
            rdata_q <= rsp_mux;
            state_q <= S_RSP;
          end else if (expire) begin
            rdata_q <= '1;
            state_q <= S_RSP;
          end
        end
        default: begin
          if (rsp_ready) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign ch_req_valid = (state_q == S_REQ) ? sel_q : '0;
  assign ch_rsp_ready = ready_q ? '1 : ((state_q == S_WAIT) ? sel_q : '0);
  assign ch_req_write = write_q;
  assign ch_req_addr  = addr_q;
  assign ch_req_wid   = wid_q;
  assign ch_req_tmask = tmask_q;
  assign ch_req_data  = wdata_q;
  assign rsp_valid    = (state_q == S_RSP);
  assign rsp_wid      = wid_q;
  assign rsp_tmask    = tmask_q;
  assign rsp_data     = rdata_q;
  assign rsp_tag      = tag_q;
  assign rsp_miss     = miss_q;

endmodule

// File: tb/tb_vx_csr_router.sv
// Scoreboard bench for vx_csr_router: expected responses queued at issue, compared at the response handshake.
module tb_vx_csr_router;

  localparam int NL = 4;
  localparam int NC = 3;
  localparam int WW = 2;
  localparam int TW = 32;
  localparam int DW = NL * 32;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [11:0]         req_addr;
  logic [WW-1:0]       req_wid;
  logic [NL-1:0]       req_tmask;
  logic [DW-1:0]       req_data;
  logic [TW-1:0]       req_tag;
  logic [NC-1:0]       ch_req_valid;
  logic [NC-1:0]       ch_req_ready;
  logic                ch_req_write;
  logic [11:0]         ch_req_addr;
  logic [WW-1:0]       ch_req_wid;
  logic [NL-1:0]       ch_req_tmask;
  logic [DW-1:0]       ch_req_data;
  logic [NC-1:0]       ch_rsp_valid;
  logic [NC*DW-1:0]    ch_rsp_data;
  logic [NC-1:0]       ch_rsp_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WW-1:0]       rsp_wid;
  logic [NL-1:0]       rsp_tmask;
  logic [DW-1:0]       rsp_data;
  logic [TW-1:0]       rsp_tag;
  logic                rsp_miss;
  logic                rsp_err;
  logic [7:0]          timeout_cnt;

  vx_csr_router #(
    .NUM_LANES      (NL),
    .NUM_CHANNELS   (NC),
    .WID_WIDTH      (WW),
    .TAG_WIDTH      (TW),
    .CH_BASE        ({12'h800, 12'hC00, 12'h800}),
    .CH_SIZE        ({12'h200, 12'h010, 12'h100}),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wid      (req_wid),
    .req_tmask    (req_tmask),
    .req_data     (req_data),
    .req_tag      (req_tag),
    .ch_req_valid (ch_req_valid),
    .ch_req_ready (ch_req_ready),
    .ch_req_write (ch_req_write),
    .ch_req_addr  (ch_req_addr),
    .ch_req_wid   (ch_req_wid),
    .ch_req_tmask (ch_req_tmask),
    .ch_req_data  (ch_req_data),
    .ch_rsp_valid (ch_rsp_valid),
    .ch_rsp_data  (ch_rsp_data),
    .ch_rsp_ready (ch_rsp_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_wid      (rsp_wid),
    .rsp_tmask    (rsp_tmask),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag),
    .rsp_miss     (rsp_miss),
    .rsp_err      (rsp_err),
    .timeout_cnt  (timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] wid;
    logic [NL-1:0] tmask;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          miss;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   err_cnt   = 0;
  int   rsp_num   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [WW-1:0] wid, input logic [NL-1:0] tmask,
                          input logic [DW-1:0] data, input logic [TW-1:0] tag,
                          input logic miss, input logic err);
    exp_t e;
    e.wid = wid; e.tmask = tmask; e.data = data; e.tag = tag; e.miss = miss; e.err = err;
    exp_q.push_back(e);
  endtask

  // Returns one cycle after the accept edge (cycle 1 relative to accept)
  task automatic issue(input logic wr, input logic [11:0] addr, input logic [WW-1:0] wid,
                       input logic [NL-1:0] tmask, input logic [DW-1:0] data, input logic [TW-1:0] tag);
    int n;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wid = wid;
    req_tmask = tmask; req_data = data; req_tag = tag;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("req_ready_wait", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && rsp_valid && rsp_ready) begin
        rsp_num++;
        $display("rsp %0d: wid=%0d tmask=%h tag=%h miss=%b err=%b data=%h",
                 rsp_num, rsp_wid, rsp_tmask, rsp_tag, rsp_miss, rsp_err, rsp_data);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("rsp_wid",   rsp_wid,   e.wid);
          check("rsp_tmask", rsp_tmask, e.tmask);
          check("rsp_data",  rsp_data,  e.data);
          check("rsp_tag",   rsp_tag,   e.tag);
          check("rsp_miss",  rsp_miss,  e.miss);
          check("rsp_err",   rsp_err,   e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", err_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd0, rd1, rd2, ones;
    rd0  = {4{32'hA5A5_0001}};
    rd1  = {4{32'h3333_1111}};
    rd2  = {4{32'h0000_CAFE}};
    ones = '1;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wid = '0;
    req_tmask = '0; req_data = '0; req_tag = '0; ch_req_ready = '0; ch_rsp_valid = '0;
    ch_rsp_data = {{4{32'h5555_5555}}, {4{32'h3333_3333}}, {4{32'h1111_1111}}};
    rsp_ready = 1'b1;

    repeat (2) tick();
    check("rst_req_ready",  req_ready,    0);
    check("rst_rsp_valid",  rsp_valid,    0);
    check("rst_ch_req_vld", ch_req_valid, 0);
    check("rst_ch_rsp_rdy", ch_rsp_ready, 0);
    check("rst_rsp_data",   rsp_data,     0);
    check("rst_to_cnt",     timeout_cnt,  0);
    reset_n = 1'b1;
    tick();
    check("ready_after_rst", req_ready, 1);
    check("idle_drain_rdy",  ch_rsp_ready, 3'b111);

    // miss
    push_exp(2'd1, 4'hF, '0, 32'h1111_0000, 1'b1, 1'b0);
    issue(1'b0, 12'h7FF, 2'd1, 4'hF, {4{32'h1234_5678}}, 32'h1111_0000);
    check("miss_lat", rsp_valid, 1);
    check("miss_chv", ch_req_valid, 0);
    tick();

    // write with ch_req_ready low for 3 cycles
    ch_req_ready = '0;
    push_exp(2'd2, 4'hA, '0, 32'h2222_0000, 1'b0, 1'b0);
    issue(1'b1, 12'hC05, 2'd2, 4'hA, {4{32'hDEAD_BEEF}}, 32'h2222_0000);
    check("wr_addr",  ch_req_addr,  12'hC05);
    check("wr_write", ch_req_write, 1);
    check("wr_data",  ch_req_data,  {4{32'hDEAD_BEEF}});
    check("wr_wid",   ch_req_wid,   2'd2);
    for (int k = 1; k <= 4; k++) begin
      check("wr_chv",     ch_req_valid, 3'b010);
      check("wr_no_rsp",  rsp_valid,    0);
      if (k == 4) ch_req_ready = 3'b010;
      tick();
    end
    check("wr_rsp_lat", rsp_valid, 1);
    check("wr_chv_off", ch_req_valid, 0);
    ch_req_ready = '0;
    tick();

    // read from channel 0, response 4 cycles after handshake
    ch_req_ready = 3'b001;
    push_exp(2'd3, 4'h5, rd0, 32'h3333_0000, 1'b0, 1'b0);
    issue(1'b0, 12'h810, 2'd3, 4'h5, '0, 32'h3333_0000);
    check("rd0_chv", ch_req_valid, 3'b001);
    tick();
    for (int k = 2; k <= 5; k++) begin
      check("rd0_no_rsp", rsp_valid, 0);
      check("rd0_rsp_rdy", ch_rsp_ready, 3'b001);
      if (k == 5) begin
        ch_rsp_valid = 3'b001;
        ch_rsp_data[0 +: DW] = rd0;
      end
      tick();
    end
    check("rd0_rsp_lat", rsp_valid, 1);
    ch_rsp_valid = '0;
    tick();

    // zero-wait read from channel 2
    ch_req_ready = 3'b100;
    ch_rsp_valid = 3'b100;
    ch_rsp_data[2*DW +: DW] = rd2;
    push_exp(2'd0, 4'h3, rd2, 32'h4444_0000, 1'b0, 1'b0);
    issue(1'b0, 12'h950, 2'd0, 4'h3, '0, 32'h4444_0000);
    check("rd2_chv", ch_req_valid, 3'b100);
    check("rd2_c1",  rsp_valid,    0);
    tick();
    check("rd2_c2",  rsp_valid,    0);
    tick();
    check("rd2_c3",  rsp_valid,    1);
    ch_rsp_valid = '0;
    tick();

    // overlap at 0x800 picks channel 0; then hold rsp_ready low for 5 cycles
    ch_req_ready = 3'b001;
    ch_rsp_valid = 3'b001;
    ch_rsp_data[0 +: DW] = {4{32'h0BAD_F00D}};
    rsp_ready = 1'b0;
    push_exp(2'd1, 4'h9, {4{32'h0BAD_F00D}}, 32'h5555_0000, 1'b0, 1'b0);
    issue(1'b0, 12'h800, 2'd1, 4'h9, '0, 32'h5555_0000);
    check("ovl_chv", ch_req_valid, 3'b001);
    tick();
    tick();
    ch_rsp_valid = '0;
    ch_rsp_data[0 +: DW] = {4{32'hFFFF_0000}};
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data",  rsp_data,  {4{32'h0BAD_F00D}});
      check("bp_tag",   rsp_tag,   32'h5555_0000);
      tick();
    end
    rsp_ready = 1'b1;
    tick();

`ifdef CSR_ROUTER_TIMEOUT_EN
    // channel 1 never accepts: abort after 8 cycles in REQ/WAIT
    ch_req_ready = '0;
    push_exp(2'd2, 4'hF, ones, 32'h6666_0000, 1'b0, 1'b1);
    issue(1'b0, 12'hC01, 2'd2, 4'hF, '0, 32'h6666_0000);
    for (int k = 1; k <= 8; k++) begin
      check("to_wait", rsp_valid, 0);
      tick();
    end
    check("to_rsp",   rsp_valid,   1);
    check("to_cnt",   timeout_cnt, 1);
    tick();
    ch_rsp_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      check("late_drain_rdy", ch_rsp_ready, 3'b111);
      check("late_no_rsp",    rsp_valid,    0);
      tick();
    end
    ch_rsp_valid = '0;

    // handshake on the threshold cycle wins over the timeout
    push_exp(2'd3, 4'h1, '0, 32'h7777_0000, 1'b0, 1'b0);
    issue(1'b1, 12'hC02, 2'd3, 4'h1, {4{32'h0000_0042}}, 32'h7777_0000);
    for (int k = 1; k <= 8; k++) begin
      check("tie_wait", rsp_valid, 0);
      if (k == 8) ch_req_ready = 3'b010;
      tick();
    end
    check("tie_rsp", rsp_valid,   1);
    check("tie_cnt", timeout_cnt, 1);
    ch_req_ready = '0;
    tick();
`else
    // without the timer a stalled channel is waited on indefinitely
    ch_req_ready = '0;
    push_exp(2'd2, 4'hF, rd1, 32'h6666_0000, 1'b0, 1'b0);
    issue(1'b0, 12'hC01, 2'd2, 4'hF, '0, 32'h6666_0000);
    for (int k = 1; k <= 20; k++) begin
      check("stall_wait", rsp_valid, 0);
      tick();
    end
    check("stall_chv", ch_req_valid, 3'b010);
    ch_req_ready = 3'b010;
    tick();
    ch_rsp_valid = 3'b010;
    ch_rsp_data[DW +: DW] = rd1;
    tick();
    check("stall_rsp", rsp_valid,   1);
    check("stall_err", rsp_err,     0);
    check("stall_cnt", timeout_cnt, 0);
    ch_rsp_valid = '0;
    ch_req_ready = '0;
    tick();
`endif

    // asynchronous reset while in WAIT: no response for the aborted read
    ch_req_ready = 3'b001;
    issue(1'b0, 12'h820, 2'd1, 4'h7, '0, 32'h8888_0000);
    tick();
    check("mid_wait_rdy", ch_rsp_ready, 3'b001);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_rsp_valid", rsp_valid,    0);
    check("arst_req_ready", req_ready,    0);
    check("arst_ch_req",    ch_req_valid, 0);
    check("arst_ch_rsp",    ch_rsp_ready, 0);
    check("arst_to_cnt",    timeout_cnt,  0);
    check("arst_rsp_data",  rsp_data,     0);
    ch_req_ready = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rel_ready", req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      check("rel_no_rsp", rsp_valid, 0);
      tick();
    end

    // normal operation resumes after reset
    push_exp(2'd0, 4'h2, '0, 32'h9999_0000, 1'b1, 1'b0);
    issue(1'b0, 12'h100, 2'd0, 4'h2, '0, 32'h9999_0000);
    check("post_rst_miss", rsp_valid, 1);
    repeat (3) tick();

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

endmodule
